// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store sequencer.
// Also provides the funct3 legality and alignment checks used at accept time.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        FAULT
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] EXT_SB = 2'b00;
    localparam logic [1:0] EXT_SH = 2'b01;
    localparam logic [1:0] EXT_W  = 2'b10;
    localparam logic [1:0] EXT_U  = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_LH, F3_LHU: return a[0];
            F3_LW:         return a != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory request/ready bus between the LSU (master) and memory (slave).
interface lsu_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering: byte enables, store replication, load shift/mask and
// the matching extension select, all from funct3 and the low address bits.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_aligned,
    output logic [1:0]  sign_sel
);

    always_comb begin
        be            = '0;
        wdata_lane    = wdata;
        rdata_aligned = rdata;
        sign_sel      = EXT_W;
        case (funct3)
            F3_LB, F3_LBU: begin
                be            = 4'b0001 << addr_lo;
                wdata_lane    = {4{wdata[7:0]}};
                rdata_aligned = rdata >> {addr_lo, 3'b000};
                if (funct3 == F3_LBU) begin
                    rdata_aligned[31:8] = '0;
                    sign_sel            = EXT_U;
                end else begin
                    sign_sel = EXT_SB;
                end
            end
            F3_LH, F3_LHU: begin
                be            = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane    = {2{wdata[15:0]}};
                rdata_aligned = rdata >> {addr_lo[1], 4'b0000};
                if (funct3 == F3_LHU) begin
                    rdata_aligned[31:16] = '0;
                    sign_sel             = EXT_U;
                end else begin
                    sign_sel = EXT_SH;
                end
            end
            F3_LW: begin
                be = 4'b1111;
            end
            default: begin
                be = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store sequencer: alignment check, req/ready handshake
// with timeout, lane steering and pipeline stall generation.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_read,
    input  logic              ex_write,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic [1:0]        SignEXM,
    output logic              misalign,
    output logic              bus_err,
    lsu_ctrl_if.master        dmem
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        done_q, done_d;
    logic        misalign_q, misalign_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] load_data_q, load_data_d;
    logic [1:0]  sign_q, sign_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic [1:0]  lane_sign;

    lsu_lane u_lane (
        .funct3        (funct3_q),
        .addr_lo       (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata         (dmem.dmem_rdata),
        .be            (lane_be),
        .wdata_lane    (lane_wdata),
        .rdata_aligned (lane_rdata),
        .sign_sel      (lane_sign)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        req_d       = 1'b0;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        load_data_d = '0;
        sign_d      = EXT_W;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && (ex_read || ex_write)) begin
                    stall    = 1'b1;
                    addr_d   = ex_addr;
                    funct3_d = ex_funct3;
                    wdata_d  = ex_wdata;
                    we_d     = ex_write;
                    cnt_d    = '0;
                    // Illegal op takes precedence so only one fault flag is raised.
                    if ((ex_read && ex_write) || !f3_legal(ex_funct3)) begin
                        state_d   = FAULT;
                        done_d    = 1'b1;
                        bus_err_d = 1'b1;
                    end else if (f3_misaligned(ex_funct3, ex_addr[1:0])) begin
                        state_d    = FAULT;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                // Ready is checked before the timeout so a late handshake still wins.
                if (dmem.dmem_ready) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        load_data_d = lane_rdata;
                        sign_d      = lane_sign;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d   = FAULT;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    req_d = 1'b1;
                end
            end
            RESP, FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            load_data_q <= '0;
            sign_q      <= EXT_W;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            load_data_q <= load_data_d;
            sign_q      <= sign_d;
        end
    end

    assign done      = done_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign load_data = load_data_q;
    assign SignEXM   = sign_q;

    // Bus fields are gated by the request so nothing leaks out while idle or faulting.
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = req_q & we_q;
    assign dmem.dmem_addr  = req_q ? {addr_q[31:2], 2'b00} : '0;
    assign dmem.dmem_be    = req_q ? lane_be : '0;
    assign dmem.dmem_wdata = (req_q && we_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl against a transaction-level model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_read = 1'b0;
    logic        ex_write = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  SignEXM;
    logic        misalign;
    logic        bus_err;

    lsu_ctrl_if dmem_if ();

    lsu_ctrl #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_read   (ex_read),
        .ex_write  (ex_write),
        .ex_funct3 (ex_funct3),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .SignEXM   (SignEXM),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .dmem      (dmem_if.master)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes from funct3 (only meaningful for legal codes).
    function automatic int unsigned m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Returns {misalign, bus_err}.
    function automatic logic [1:0] m_fault(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [31:0] a);
        if ((rd && wr) || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b01;
        if ((a % m_size(f3)) != 0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned mask;
        int unsigned off;
        off  = a % 32'd4;
        mask = ((32'd1 << m_size(f3)) - 1) << off;
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
        case (m_size(f3))
            1:       return {4{w[7:0]}};
            2:       return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] r);
        logic [31:0] v;
        int unsigned off;
        off = a % 32'd4;
        v   = r >> (8 * off);
        if (f3[2]) v = v & ((32'd1 << (8 * m_size(f3))) - 1);
        return v;
    endfunction

    function automatic logic [1:0] m_ext(input logic [2:0] f3);
        if (f3[2]) return EXT_U;
        case (m_size(f3))
            1:       return EXT_SB;
            2:       return EXT_SH;
            default: return EXT_W;
        endcase
    endfunction

    // One operation: accept in cycle 0, memory raises ready after dly low cycles
    // in REQ (dly > TO means never), every cycle up to completion is checked.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int unsigned dly, input logic [31:0] rdv);
        logic [1:0]  flt;
        int unsigned done_c;
        flt = m_fault(rd, wr, f3, a);
        if (flt != 2'b00)  done_c = 1;
        else if (dly <= TO) done_c = dly + 2;
        else               done_c = TO + 2;

        tick();
        ex_valid  = 1'b1;
        ex_read   = rd;
        ex_write  = wr;
        ex_funct3 = f3;
        ex_addr   = a;
        ex_wdata  = wd;
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = $urandom;
        @(negedge clk);
        check_eq("acc_stall", stall, 1);
        check_eq("acc_done", done, 0);
        check_eq("acc_req", dmem_if.dmem_req, 0);

        for (int unsigned c = 1; c <= done_c; c++) begin
            tick();
            // Garbage on the execute side must be ignored while busy.
            ex_valid  = 1'($urandom_range(0, 1));
            ex_read   = 1'($urandom_range(0, 1));
            ex_write  = 1'($urandom_range(0, 1));
            ex_funct3 = 3'($urandom_range(0, 7));
            ex_addr   = $urandom;
            ex_wdata  = $urandom;
            dmem_if.dmem_rdata = (c == dly + 1) ? rdv : $urandom;
            if (c < done_c) dmem_if.dmem_ready = (flt == 2'b00) && (c == dly + 1);
            else            dmem_if.dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c < done_c) begin
                check_eq("req", dmem_if.dmem_req, 1);
                check_eq("we", dmem_if.dmem_we, wr);
                check_eq("addr", dmem_if.dmem_addr, a & 32'hFFFF_FFFC);
                check_eq("be", dmem_if.dmem_be, m_be(f3, a));
                check_eq("wdata", dmem_if.dmem_wdata, wr ? m_wdata(f3, wd) : 32'd0);
                check_eq("busy_stall", stall, 1);
                check_eq("busy_done", done, 0);
            end else begin
                check_eq("done", done, 1);
                check_eq("done_stall", stall, 0);
                check_eq("done_req", dmem_if.dmem_req, 0);
                check_eq("misalign", misalign, flt[1]);
                check_eq("bus_err", bus_err, (flt == 2'b00) ? (dly > TO) : flt[0]);
                if (flt == 2'b00 && dly <= TO) begin
                    check_eq("load_data", load_data, wr ? 32'd0 : m_load(f3, a, rdv));
                    check_eq("SignEXM", SignEXM, wr ? EXT_W : m_ext(f3));
                end
            end
        end
        ex_valid = 1'b0;
        dmem_if.dmem_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        tick();
        @(negedge clk);
        check_eq({tag, "_stall"}, stall, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_req"}, dmem_if.dmem_req, 0);
    endtask

    initial begin
        logic [2:0] legal_f3 [5];
        logic [2:0] bad_f3 [3];
        legal_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        bad_f3   = '{3'b011, 3'b110, 3'b111};
        dmem_if.dmem_ready = 1'b0;
        dmem_if.dmem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_load", load_data, 0);
        check_eq("rst_sign", SignEXM, EXT_W);
        check_eq("rst_mis", misalign, 0);
        check_eq("rst_berr", bus_err, 0);
        check_eq("rst_req", dmem_if.dmem_req, 0);
        check_eq("rst_we", dmem_if.dmem_we, 0);
        check_eq("rst_addr", dmem_if.dmem_addr, 0);
        check_eq("rst_be", dmem_if.dmem_be, 0);
        check_eq("rst_wdata", dmem_if.dmem_wdata, 0);
        tick();
        rst_n = 1'b1;

        run_op(1, 0, F3_LB,  32'h0000_1003, 32'h0, 0, 32'hA000_0000);
        run_op(1, 0, F3_LHU, 32'h0000_2002, 32'h0, 0, 32'hF000_1234);
        run_op(1, 0, F3_LH,  32'h0000_2002, 32'h0, 0, 32'hF000_1234);
        run_op(0, 1, F3_LB,  32'h0000_3001, 32'h0000_005A, 0, 32'h0);
        run_op(1, 0, F3_LW,  32'h0000_4002, 32'h0, 0, 32'h0);
        run_op(1, 0, F3_LW,  32'h0000_5000, 32'h0, TO + 1, 32'h0);
        idle_check("post_to");
        run_op(1, 0, F3_LW,  32'h0000_5000, 32'h0, TO, 32'hCAFE_F00D);
        run_op(1, 1, F3_LW,  32'h0000_6000, 32'h0, 0, 32'h0);
        run_op(1, 0, 3'b011, 32'h0000_6000, 32'h0, 0, 32'h0);
        run_op(0, 1, F3_LH,  32'h0000_7003, 32'h1234_5678, 0, 32'h0);

        // Reset while a request is outstanding.
        tick();
        ex_valid = 1'b1; ex_read = 1'b1; ex_write = 1'b0;
        ex_funct3 = F3_LW; ex_addr = 32'h0000_8000;
        tick();
        ex_valid = 1'b0;
        @(negedge clk);
        check_eq("rq_req", dmem_if.dmem_req, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rq_rst_req", dmem_if.dmem_req, 0);
        check_eq("rq_rst_stall", stall, 0);
        check_eq("rq_rst_done", done, 0);
        idle_check("rq_after");

        for (int i = 0; i < 250; i++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            int unsigned r, dly;
            r = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r >= 6);
            f3 = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)]
                                            : bad_f3[$urandom_range(0, 2)];
            r = $urandom_range(0, 9);
            if (r < 7)      dly = $urandom_range(0, 3);
            else if (r < 9) dly = $urandom_range(TO - 1, TO);
            else            dly = TO + 1;
            run_op(rd, wr, f3, $urandom, $urandom, dly, $urandom);
            if ($urandom_range(0, 3) == 0) idle_check("gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
